// File: rtl/crc_encoder.sv
// ============================================================================
// Module   : crc_encoder
// Brief    : Serial (one bit per clock, MSB first) CRC encoder. Latches a
//            parallel message and a run-time generator polynomial, computes
//            the remainder by plain polynomial division (init 0, no
//            reflection, no final XOR) and launches the codeword
//            {msg, crc} to a downstream decoder with a one-cycle ctrlen
//            strobe once the decoder reports ready.
// Options  : CRC_ENCODER_ERRINJ_EN - adds an errinj port whose value, latched
//            at start, is XORed into the launched codeword.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_encoder #(
  parameter int DATAWIDTH = 48,
  parameter int CRCWIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [DATAWIDTH-CRCWIDTH-1:0] msgin,
  input  logic [CRCWIDTH:0]             genPoly,
  input  logic                          dec_ready,
`ifdef CRC_ENCODER_ERRINJ_EN
  input  logic [DATAWIDTH-1:0]          errinj,
`endif
  output logic                          encready,
  output logic                          ctrlen,
  output logic [DATAWIDTH-1:0]          dataout,
  output logic [CRCWIDTH:0]             genPolyout
);

  localparam int MSGWIDTH = DATAWIDTH - CRCWIDTH;
  localparam int CNTWIDTH = 9;
  localparam logic [CNTWIDTH-1:0] C_LAST_BIT = CNTWIDTH'(MSGWIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [MSGWIDTH-1:0]  r_shift;     // consumed MSB first during CALC
  logic [MSGWIDTH-1:0]  r_msg;       // untouched copy for the codeword
  logic [CRCWIDTH-1:0]  r_crc;
  logic [CNTWIDTH-1:0]  r_cnt;
  logic [DATAWIDTH-1:0] r_dataout;
  logic [CRCWIDTH:0]    r_genpoly;

  logic                 w_msgbit;
  logic                 w_fb;
  logic                 w_last;
  logic [CRCWIDTH-1:0]  w_crc_next;
  logic [DATAWIDTH-1:0] w_codeword;

  assign w_msgbit   = r_shift[MSGWIDTH-1];
  assign w_fb       = r_crc[CRCWIDTH-1] ^ w_msgbit;
  assign w_last     = (r_cnt == C_LAST_BIT);
  // The x^CRCWIDTH term of the polynomial is implicit: only the low bits feed back.
  assign w_crc_next = {r_crc[CRCWIDTH-2:0], 1'b0}
                    ^ (w_fb ? r_genpoly[CRCWIDTH-1:0] : {CRCWIDTH{1'b0}});

`ifdef CRC_ENCODER_ERRINJ_EN
  logic [DATAWIDTH-1:0] r_errinj;
  assign w_codeword = {r_msg, w_crc_next} ^ r_errinj;

  // Error pattern captured together with the message so later changes have no effect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_errinj <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_errinj <= errinj;
    end
  end
`else
  assign w_codeword = {r_msg, w_crc_next};
`endif

  // Next-state decode; dec_ready matters only in HOLD, EMIT always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_state_next = S_CALC;
      S_CALC:  if (w_last)    w_state_next = S_HOLD;
      S_HOLD:  if (dec_ready) w_state_next = S_EMIT;
      S_EMIT:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: latch at start, shift/divide in CALC, publish codeword on HOLD entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift   <= '0;
      r_msg     <= '0;
      r_crc     <= '0;
      r_cnt     <= '0;
      r_dataout <= '0;
      r_genpoly <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= msgin;
            r_msg     <= msgin;
            r_genpoly <= genPoly;
            r_crc     <= '0;
            r_cnt     <= '0;
          end
        end
        S_CALC: begin
          r_crc   <= w_crc_next;
          r_shift <= {r_shift[MSGWIDTH-2:0], 1'b0};
          if (w_last) begin
            // Last bit: the freshly computed remainder goes straight into the codeword.
            r_cnt     <= '0;
            r_dataout <= w_codeword;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign encready   = (r_state == S_IDLE);
  assign ctrlen     = (r_state == S_EMIT);
  assign dataout    = r_dataout;
  assign genPolyout = r_genpoly;

endmodule

`default_nettype wire

// File: tb/tb_crc_encoder.sv
// ============================================================================
// Module   : tb_crc_encoder
// Brief    : Self-checking bench for crc_encoder. A cycle-level reference
//            model computes the expected codeword by long division of
//            msg * x^8 and tracks the launch timeline; directed cases pin the
//            literal codewords and timing, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_encoder;

  localparam int DW = 48;
  localparam int CW = 8;
  localparam int MW = DW - CW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start;
  logic [MW-1:0] msgin;
  logic [CW:0]   genPoly;
  logic          dec_ready;
  logic [DW-1:0] errinj;
  logic          encready;
  logic          ctrlen;
  logic [DW-1:0] dataout;
  logic [CW:0]   genPolyout;

  int n_checks = 0;
  int n_errors = 0;

  crc_encoder #(.DATAWIDTH(DW), .CRCWIDTH(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .msgin      (msgin),
    .genPoly    (genPoly),
    .dec_ready  (dec_ready),
`ifdef CRC_ENCODER_ERRINJ_EN
    .errinj     (errinj),
`endif
    .encready   (encready),
    .ctrlen     (ctrlen),
    .dataout    (dataout),
    .genPolyout (genPolyout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of m(x) * x^8 divided by x^8 + p[7:0](x), by textbook long division.
  function automatic logic [7:0] crc_div(input logic [8:0] p, input logic [MW-1:0] m);
    logic [DW-1:0] v;
    v = {m, 8'h00};
    for (int i = DW - 1; i >= CW; i--) begin
      if (v[i]) v[i -: 9] = v[i -: 9] ^ {1'b1, p[7:0]};
    end
    return v[7:0];
  endfunction

  // Reference timeline: m_age = edges since acceptance (-1 when idle).
  int            m_age = -1;
  bit            m_emit = 1'b0;
  logic [MW-1:0] m_msg = '0;
  logic [DW-1:0] m_inj = '0;
  logic [DW-1:0] exp_data = '0;
  logic [CW:0]   exp_gp = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_age = -1; m_emit = 1'b0; exp_data = '0; exp_gp = '0;
    end else if (m_emit) begin
      m_emit = 1'b0; m_age = -1;
    end else if (m_age < 0) begin
      if (start) begin
        m_age = 0; m_msg = msgin; exp_gp = genPoly;
`ifdef CRC_ENCODER_ERRINJ_EN
        m_inj = errinj;
`else
        m_inj = '0;
`endif
      end
    end else if (m_age < MW) begin
      m_age++;
      if (m_age == MW) exp_data = {m_msg, crc_div(exp_gp, m_msg)} ^ m_inj;
    end else if (dec_ready) begin
      m_emit = 1'b1;
    end
  end

  // Every cycle: DUT outputs must match the reference model.
  always @(negedge clk) begin
    check("encready", 64'(encready), 64'(m_age < 0));
    check("ctrlen", 64'(ctrlen), 64'(m_emit));
    check("dataout", 64'(dataout), 64'(exp_data));
    check("genPolyout", 64'(genPolyout), 64'(exp_gp));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one message when idle and wait for its strobe (both waits bounded).
  task automatic run_one(input logic [8:0] p, input logic [MW-1:0] m);
    int n;
    n = 0;
    while (!encready && n < 200) begin tick(); n++; end
    check("idle_before_start", 64'(encready), 64'd1);
    start = 1'b1; msgin = m; genPoly = p;
    tick();
    start = 1'b0;
    n = 0;
    while (!ctrlen && n < 200) begin tick(); n++; end
    check("ctrlen_seen", 64'(ctrlen), 64'd1);
  endtask

  initial begin
    int n;
    start = 1'b0; msgin = '0; genPoly = '0; dec_ready = 1'b1; errinj = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_encready", 64'(encready), 64'd1);
    check("rst_ctrlen", 64'(ctrlen), 64'd0);
    check("rst_dataout", 64'(dataout), 64'd0);
    check("rst_genpolyout", 64'(genPolyout), 64'd0);
    resetn = 1'b1;

    // Pin the reference division to hand-computed remainders.
    check("model_msg1", 64'(crc_div(9'h107, 40'h1)), 64'h07);
    check("model_msg2", 64'(crc_div(9'h107, 40'h2)), 64'h0E);
    check("model_msg0", 64'(crc_div(9'h107, 40'h0)), 64'h00);

    // msg=1: single strobe 41 edges after the accepting edge.
    tick();
    start = 1'b1; msgin = 40'h1; genPoly = 9'h107;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(encready), 64'd0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ctrlen) begin n = i; break; end
    end
    check("latency", 64'(n), 64'd41);
    check("data_msg1", 64'(dataout), 64'h0000_0000_0107);
    check("gp_msg1", 64'(genPolyout), 64'h107);
    tick();
    check("single_pulse", 64'(ctrlen), 64'd0);
    check("idle_after_emit", 64'(encready), 64'd1);

    run_one(9'h107, 40'h2);
    check("data_msg2", 64'(dataout), 64'h0000_0000_020E);
    run_one(9'h107, 40'h0);
    check("data_msg0", 64'(dataout), 64'h0);

    // Decoder busy for 20 cycles after HOLD entry.
    tick(); tick();
    dec_ready = 1'b0;
    start = 1'b1; msgin = 40'h2; genPoly = 9'h107;
    tick();
    start = 1'b0;
    repeat (MW) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_no_ctrlen", 64'(ctrlen), 64'd0);
      check("hold_stable", 64'(dataout), 64'h0000_0000_020E);
    end
    dec_ready = 1'b1;
    tick();
    check("ctrlen_after_ready", 64'(ctrlen), 64'd1);
    tick();
    check("ctrlen_one_cycle", 64'(ctrlen), 64'd0);

    // Second start during CALC must be ignored.
    start = 1'b1; msgin = 40'h1; genPoly = 9'h107;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; msgin = 40'h2; genPoly = 9'h1FF;
    tick();
    start = 1'b0;
    n = 0;
    while (!ctrlen && n < 200) begin tick(); n++; end
    check("ignored_start_data", 64'(dataout), 64'h0000_0000_0107);
    check("ignored_start_gp", 64'(genPolyout), 64'h107);
    tick();

    // Asynchronous reset mid-CALC.
    start = 1'b1; msgin = 40'h2; genPoly = 9'h107;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 resetn = 1'b0;
    #1;
    check("async_rst_encready", 64'(encready), 64'd1);
    check("async_rst_ctrlen", 64'(ctrlen), 64'd0);
    check("async_rst_dataout", 64'(dataout), 64'd0);
    check("async_rst_gp", 64'(genPolyout), 64'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("no_ctrlen_after_abort", 64'(ctrlen), 64'd0);
    end

`ifdef CRC_ENCODER_ERRINJ_EN
    errinj = 48'h1;
    run_one(9'h107, 40'h1);
    check("errinj_data", 64'(dataout), 64'h0000_0000_0106);
    tick();
    errinj = '0;
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      start     = 1'($urandom_range(0, 1));
      msgin     = MW'({$urandom(), $urandom()});
      genPoly   = 9'($urandom());
      dec_ready = ($urandom_range(0, 3) != 0);
`ifdef CRC_ENCODER_ERRINJ_EN
      errinj    = ($urandom_range(0, 3) == 0) ? DW'({$urandom(), $urandom()}) : '0;
`endif
      tick();
    end
    start = 1'b0; dec_ready = 1'b1;
    repeat (100) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc_encoder.md
# crc_encoder

Upstream companion to the CRC decoder: accepts a parallel message word, computes its CRC serially (one message bit per clock, MSB first) against a run-time generator polynomial, and presents the appended codeword to the decoder. It generates the decoder's one-cycle `ctrlen` strobe and the polynomial it needs. It launches a codeword only when the decoder reports `crcready`.

## Interface
Parameters:
- `DATAWIDTH`, 48, codeword width; must equal the decoder's `DATAWIDTH`.
- `CRCWIDTH`, 8, CRC width; message width `MSGWIDTH = DATAWIDTH - CRCWIDTH` (40).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  message valid; sampled only while `encready`=1.
- `msgin`  in  MSGWIDTH  message; bit MSGWIDTH-1 is processed first.
- `genPoly`  in  CRCWIDTH+1  generator polynomial; bit CRCWIDTH is the implicit x^CRCWIDTH term and is ignored by the arithmetic.
- `dec_ready`  in  1  downstream decoder idle; connects to the decoder's `crcready`.
- `encready`  out  1  high only in IDLE.
- `ctrlen`  out  1  one-cycle launch strobe to the decoder.
- `dataout`  out  DATAWIDTH  codeword `{msg, crc}`.
- `genPolyout`  out  CRCWIDTH+1  polynomial latched at `start`; drives the decoder's `genPoly`.

## Operation
- FSM states: IDLE, CALC, HOLD, EMIT.
- IDLE: `start`=1 latches `msgin` into a shift register and `genPoly` into `genPolyout`, clears `crc` and the bit counter, then goes to CALC.
- CALC: one bit per cycle. `fb = crc[CRCWIDTH-1] ^ msgbit`. Next `crc = {crc[CRCWIDTH-2:0],1'b0} ^ (fb ? genPolyout[CRCWIDTH-1:0] : 0)`. The message register then shifts left by 1.
  - The counter runs 0..MSGWIDTH-1. The counter is 9 bits and wraps to 0 on exit.
  - After bit MSGWIDTH-1, go to HOLD and load `dataout = {latched msg, crc}`.
- HOLD: stay until `dec_ready`=1. Then go to EMIT.
- EMIT: `ctrlen`=1 for exactly this cycle. Next state is IDLE unconditionally.
- `start` outside IDLE is ignored. `msgin` and `genPoly` changes after acceptance have no effect.
- `dataout` and `genPolyout` stay stable from HOLD entry until the next accepted `start`.
- If `dec_ready` drops while in HOLD, the block keeps waiting. There is no timeout.
- The init value is 0, with no reflection and no final XOR. This is plain polynomial division, so a decoder dividing the full codeword by the same polynomial yields remainder 0.

## Timing
- Reset values, applied asynchronously and held while `resetn`=0:
  - state = IDLE, `encready`=1, `ctrlen`=0.
  - `dataout`=0, `genPolyout`=0, `crc`=0, counter = 0.
- Reset asserted mid-CALC, HOLD or EMIT aborts immediately. No `ctrlen` is produced for the aborted message.
- `start` sampled at edge k:
  - `encready`=0 from edge k.
  - HOLD is entered at edge k+MSGWIDTH.
  - With `dec_ready`=1, `ctrlen`=1 from edge k+MSGWIDTH+1 to edge k+MSGWIDTH+2.
  - `encready`=1 again after edge k+MSGWIDTH+2.
  - Minimum start-to-start spacing is MSGWIDTH+2 cycles.
- `dec_ready` is sampled in HOLD only. It is ignored in EMIT, because the decoder's `crcready` is still high in the cycle after `ctrlen`.
- Back-to-back operation is safe: the next launch is at least MSGWIDTH+2 cycles later, by which point the decoder is busy (it needs DATAWIDTH-1 cycles).
- `start` asserted in the same cycle as the EMIT→IDLE transition is not accepted. It must be held, or reasserted while `encready`=1.

## Configuration
- `CRC_ENCODER_ERRINJ_EN`
  - Defined: adds input port `errinj` (DATAWIDTH bits), latched at `start`. In HOLD, `dataout = {msg, crc} ^ errinj`. This forces decoder errors under test.
  - Undefined: the port does not exist, and `dataout = {msg, crc}` exactly.

## Test plan
- Reset: assert `resetn`=0 mid-CALC → all outputs return to reset values asynchronously, and no `ctrlen` appears after release.
- `genPoly`=9'h107, `msgin`=40'h00_0000_0001, `dec_ready`=1 → `ctrlen` is a single pulse 41 edges after `start`, with `dataout`=48'h0000_0000_0107.
- Same polynomial, `msgin`=40'h2 → `dataout`=48'h0000_0000_020E. With `msgin`=0 → `dataout`=0.
- `dec_ready`=0 for 20 cycles after HOLD entry → no `ctrlen` and `dataout` stays stable. `ctrlen` pulses exactly one cycle after `dec_ready` rises.
- `start` pulsed during CALC with a different `msgin` → ignored; the codeword reflects the first message only.
- With `CRC_ENCODER_ERRINJ_EN`, `errinj`=48'h1 and `msgin`=40'h1 → `dataout`=48'h0000_0000_0106. A connected decoder flags the error.
